// File: rtl/serror_monitor_mc.sv
// serror_monitor_mc: multi-channel signed error monitor with delay-aligned reference,
// saturating statistics and first-mismatch capture. Optional macro: SERR_MON_MC_DISPLAY_EN.
//
//  state | meaning
//  IDLE  | no compare seen since reset/clear
//  CHECK | valid compares seen, all matched
//  FAIL  | at least one mismatch since reset/clear (sticky until clear)
module serror_monitor_mc #(
  parameter int DATAWIDTH = 32,
  parameter int CHANNELS  = 2,
  parameter int REF_DELAY = 0,
  parameter int CNT_WIDTH = 16,
  localparam int CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int BW  = CHANNELS * DATAWIDTH
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [BW-1:0]        meas,
  input  logic [BW-1:0]        ref_data,
  input  logic [CHANNELS-1:0]  valid,
  input  logic                 clear,
  output logic [CHANNELS-1:0]  err,
  output logic                 err_any,
  output logic [1:0]           status,
  output logic [CNT_WIDTH-1:0] err_count,
  output logic [CNT_WIDTH-1:0] cmp_count,
  output logic [CHW-1:0]       first_chan,
  output logic [DATAWIDTH-1:0] first_meas,
  output logic [DATAWIDTH-1:0] first_ref,
  output logic [CNT_WIDTH-1:0] first_cycle
);

  localparam int PW = $clog2(CHANNELS + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_FAIL  = 2'd2
  } state_t;

  state_t               state;
  logic [BW-1:0]        ref_al;
  logic [CHANNELS-1:0]  mm;
  logic [PW-1:0]        vld_pop;
  logic [PW-1:0]        mm_pop;
  logic [CHW-1:0]       cap_chan;
  logic [DATAWIDTH-1:0] cap_meas;
  logic [DATAWIDTH-1:0] cap_ref;
  logic [CNT_WIDTH-1:0] cycle_count;
  logic                 captured;

  generate
    if (REF_DELAY == 0) begin : g_nodly
      assign ref_al = ref_data;
    end else begin : g_dly
      logic [BW-1:0] pipe [REF_DELAY];
      always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
          for (int k = 0; k < REF_DELAY; k++) pipe[k] <= '0;
        end else begin
          pipe[0] <= ref_data;
          for (int k = 1; k < REF_DELAY; k++) pipe[k] <= pipe[k-1];
        end
      end
      assign ref_al = pipe[REF_DELAY-1];
    end
  endgenerate

  // Case inequality so that X/Z on either side reads as a mismatch in simulation.
  always_comb begin
    mm      = '0;
    vld_pop = '0;
    mm_pop  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      mm[i]   = valid[i] && (meas[i*DATAWIDTH +: DATAWIDTH] !== ref_al[i*DATAWIDTH +: DATAWIDTH]);
      vld_pop = vld_pop + PW'(valid[i]);
      mm_pop  = mm_pop + PW'(mm[i]);
    end
  end

  // Walk downwards so the lowest mismatching channel is the one left selected.
  always_comb begin
    cap_chan = '0;
    cap_meas = '0;
    cap_ref  = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (mm[i]) begin
        cap_chan = CHW'(i);
        cap_meas = meas[i*DATAWIDTH +: DATAWIDTH];
        cap_ref  = ref_al[i*DATAWIDTH +: DATAWIDTH];
      end
    end
  end

  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                   input logic [PW-1:0] b);
    logic [CNT_WIDTH:0] s;
    s = {1'b0, a} + (CNT_WIDTH+1)'(b);
    return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
  endfunction

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state       <= ST_IDLE;
      err         <= '0;
      err_any     <= 1'b0;
      err_count   <= '0;
      cmp_count   <= '0;
      first_chan  <= '0;
      first_meas  <= '0;
      first_ref   <= '0;
      first_cycle <= '0;
      captured    <= 1'b0;
      cycle_count <= '0;
    end else begin
      if (cycle_count != '1) cycle_count <= cycle_count + CNT_WIDTH'(1);
      if (clear) begin
        state       <= ST_IDLE;
        err         <= '0;
        err_any     <= 1'b0;
        err_count   <= '0;
        cmp_count   <= '0;
        first_chan  <= '0;
        first_meas  <= '0;
        first_ref   <= '0;
        first_cycle <= '0;
        captured    <= 1'b0;
      end else begin
        err       <= mm;
        err_any   <= |mm;
        cmp_count <= sat_add(cmp_count, vld_pop);
        err_count <= sat_add(err_count, mm_pop);
        if (|mm && !captured) begin
          captured    <= 1'b1;
          first_chan  <= cap_chan;
          first_meas  <= cap_meas;
          first_ref   <= cap_ref;
          first_cycle <= cycle_count;
        end
        case (state)
          ST_IDLE: begin
            if (|mm)         state <= ST_FAIL;
            else if (|valid) state <= ST_CHECK;
          end
          ST_CHECK: if (|mm) state <= ST_FAIL;
          default:           state <= ST_FAIL;
        endcase
      end
    end
  end

  assign status = state;

`ifdef SERR_MON_MC_DISPLAY_EN
  always @(posedge Clk) begin
    if (Rst && !clear) begin
      for (int i = 0; i < CHANNELS; i++)
        if (mm[i])
          $display("%0t serror_monitor_mc: ch %0d meas %0d ref %0d", $time, i,
                   $signed(meas[i*DATAWIDTH +: DATAWIDTH]), $signed(ref_al[i*DATAWIDTH +: DATAWIDTH]));
      if (|mm && state != ST_FAIL)
        $display("%0t serror_monitor_mc: first error ch %0d meas %0d ref %0d cycle %0d", $time,
                 cap_chan, $signed(cap_meas), $signed(cap_ref), cycle_count);
    end
  end
`endif

endmodule

// File: tb/tb_serror_monitor_mc.sv
// Bench for serror_monitor_mc: four instances (plain, 4-bit counters, ref delay 3 and 2)
// driven by directed and random steps, checked against an arithmetic reference model.
module tb_serror_monitor_mc;
  localparam int HN = 1024;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;

  logic [63:0] in_m [4];
  logic [63:0] in_r [4];
  logic [1:0]  in_v [4];
  logic        in_c [4];

  int checks = 0;
  int errors = 0;

  logic [1:0]  e0_err, e1_err, e2_err, e3_err;
  logic        e0_any, e1_any, e2_any, e3_any;
  logic [1:0]  e0_st, e1_st, e2_st, e3_st;
  logic [15:0] e0_ec, e2_ec, e3_ec, e0_cc, e2_cc, e3_cc, e0_fcy, e2_fcy, e3_fcy;
  logic [3:0]  e1_ec, e1_cc, e1_fcy;
  logic        e0_fch, e1_fch, e2_fch, e3_fch;
  logic [31:0] e0_fm, e1_fm, e2_fm, e3_fm, e0_fr, e1_fr, e2_fr, e3_fr;

  serror_monitor_mc #(.DATAWIDTH(32), .CHANNELS(2), .REF_DELAY(0), .CNT_WIDTH(16)) u0 (
    .Clk(Clk), .Rst(Rst), .meas(in_m[0]), .ref_data(in_r[0]), .valid(in_v[0]), .clear(in_c[0]),
    .err(e0_err), .err_any(e0_any), .status(e0_st), .err_count(e0_ec), .cmp_count(e0_cc),
    .first_chan(e0_fch), .first_meas(e0_fm), .first_ref(e0_fr), .first_cycle(e0_fcy));

  serror_monitor_mc #(.DATAWIDTH(32), .CHANNELS(2), .REF_DELAY(0), .CNT_WIDTH(4)) u1 (
    .Clk(Clk), .Rst(Rst), .meas(in_m[1]), .ref_data(in_r[1]), .valid(in_v[1]), .clear(in_c[1]),
    .err(e1_err), .err_any(e1_any), .status(e1_st), .err_count(e1_ec), .cmp_count(e1_cc),
    .first_chan(e1_fch), .first_meas(e1_fm), .first_ref(e1_fr), .first_cycle(e1_fcy));

  serror_monitor_mc #(.DATAWIDTH(32), .CHANNELS(2), .REF_DELAY(3), .CNT_WIDTH(16)) u2 (
    .Clk(Clk), .Rst(Rst), .meas(in_m[2]), .ref_data(in_r[2]), .valid(in_v[2]), .clear(in_c[2]),
    .err(e2_err), .err_any(e2_any), .status(e2_st), .err_count(e2_ec), .cmp_count(e2_cc),
    .first_chan(e2_fch), .first_meas(e2_fm), .first_ref(e2_fr), .first_cycle(e2_fcy));

  serror_monitor_mc #(.DATAWIDTH(32), .CHANNELS(2), .REF_DELAY(2), .CNT_WIDTH(16)) u3 (
    .Clk(Clk), .Rst(Rst), .meas(in_m[3]), .ref_data(in_r[3]), .valid(in_v[3]), .clear(in_c[3]),
    .err(e3_err), .err_any(e3_any), .status(e3_st), .err_count(e3_ec), .cmp_count(e3_cc),
    .first_chan(e3_fch), .first_meas(e3_fm), .first_ref(e3_fr), .first_cycle(e3_fcy));

  // Reference model state, one slot per instance.
  int          md_cyc [4];
  int          md_errc [4];
  int          md_cmpc [4];
  int          md_st [4];
  int          md_fch [4];
  int          md_fcy [4];
  int          md_n [4];
  logic [1:0]  md_err [4];
  bit          md_cap [4];
  logic [31:0] md_fm [4];
  logic [31:0] md_fr [4];
  logic [63:0] hist [4][HN];

  task automatic model_reset();
    for (int id = 0; id < 4; id++) begin
      md_cyc[id] = 0; md_errc[id] = 0; md_cmpc[id] = 0; md_st[id] = 0; md_fch[id] = 0;
      md_fcy[id] = 0; md_n[id] = 0; md_err[id] = 2'b00; md_cap[id] = 1'b0;
      md_fm[id] = '0; md_fr[id] = '0;
    end
  endtask

  task automatic model_step(input int id);
    logic [63:0] al;
    logic [1:0]  mm;
    int d, maxc, cold, nc, ne;
    d    = (id == 2) ? 3 : (id == 3) ? 2 : 0;
    maxc = (id == 1) ? 15 : 65535;
    hist[id][md_n[id] % HN] = in_r[id];
    al = (md_n[id] >= d) ? hist[id][(md_n[id] - d) % HN] : 64'd0;
    md_n[id]++;
    for (int c = 0; c < 2; c++)
      mm[c] = (in_v[id][c] === 1'b1) && (in_m[id][c*32 +: 32] !== al[c*32 +: 32]);
    cold = md_cyc[id];
    md_cyc[id] = (md_cyc[id] < maxc) ? md_cyc[id] + 1 : maxc;
    if (in_c[id]) begin
      md_err[id] = 2'b00; md_errc[id] = 0; md_cmpc[id] = 0; md_st[id] = 0; md_cap[id] = 1'b0;
      md_fch[id] = 0; md_fm[id] = '0; md_fr[id] = '0; md_fcy[id] = 0;
    end else begin
      md_err[id] = mm;
      nc = md_cmpc[id] + $countones(in_v[id]);
      ne = md_errc[id] + $countones(mm);
      md_cmpc[id] = (nc > maxc) ? maxc : nc;
      md_errc[id] = (ne > maxc) ? maxc : ne;
      if (mm != 2'b00 && !md_cap[id]) begin
        md_cap[id] = 1'b1;
        md_fch[id] = mm[0] ? 0 : 1;
        md_fm[id]  = mm[0] ? in_m[id][31:0] : in_m[id][63:32];
        md_fr[id]  = mm[0] ? al[31:0] : al[63:32];
        md_fcy[id] = cold;
      end
      if (mm != 2'b00) md_st[id] = 2;
      else if (md_st[id] == 0 && in_v[id] != 2'b00) md_st[id] = 1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_inst(input int id, input logic [1:0] err, input logic any,
                          input logic [1:0] st, input logic [15:0] ec, input logic [15:0] cc,
                          input logic fch, input logic [31:0] fm, input logic [31:0] fr,
                          input logic [15:0] fcy);
    chk($sformatf("u%0d_err", id), 64'(err), 64'(md_err[id]));
    chk($sformatf("u%0d_err_any", id), 64'(any), 64'(md_err[id] != 2'b00));
    chk($sformatf("u%0d_status", id), 64'(st), 64'(md_st[id]));
    chk($sformatf("u%0d_err_count", id), 64'(ec), 64'(md_errc[id]));
    chk($sformatf("u%0d_cmp_count", id), 64'(cc), 64'(md_cmpc[id]));
    chk($sformatf("u%0d_first_chan", id), 64'(fch), 64'(md_fch[id]));
    chk($sformatf("u%0d_first_meas", id), 64'(fm), 64'(md_fm[id]));
    chk($sformatf("u%0d_first_ref", id), 64'(fr), 64'(md_fr[id]));
    chk($sformatf("u%0d_first_cycle", id), 64'(fcy), 64'(md_fcy[id]));
  endtask

  task automatic check_all();
    chk_inst(0, e0_err, e0_any, e0_st, e0_ec, e0_cc, e0_fch, e0_fm, e0_fr, e0_fcy);
    chk_inst(1, e1_err, e1_any, e1_st, 16'(e1_ec), 16'(e1_cc), e1_fch, e1_fm, e1_fr, 16'(e1_fcy));
    chk_inst(2, e2_err, e2_any, e2_st, e2_ec, e2_cc, e2_fch, e2_fm, e2_fr, e2_fcy);
    chk_inst(3, e3_err, e3_any, e3_st, e3_ec, e3_cc, e3_fch, e3_fm, e3_fr, e3_fcy);
  endtask

  task automatic step();
    @(posedge Clk);
    for (int id = 0; id < 4; id++) model_step(id);
    #1;
    check_all();
  endtask

  task automatic drive_idle();
    for (int id = 0; id < 4; id++) begin
      in_v[id] = 2'b00;
      in_c[id] = 1'b0;
    end
  endtask

  // Drop reset between clock edges and check outputs before any further edge.
  task automatic mid_reset();
    #2 Rst = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_status_u0", 64'(e0_st), 64'd0);
    chk("rst_cmp_u0", 64'(e0_cc), 64'd0);
    @(negedge Clk);
    Rst = 1'b1;
  endtask

  logic [63:0] d;
  logic [63:0] s [20];
  logic [63:0] gs [$];
  logic [31:0] fm0;

  initial begin
    for (int id = 0; id < 4; id++) begin
      in_m[id] = '0; in_r[id] = '0; in_v[id] = 2'b00; in_c[id] = 1'b0;
    end
    #1 Rst = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge Clk);
    @(negedge Clk);
    Rst = 1'b1;

    // Matching random traffic on both channels
    for (int k = 0; k < 50; k++) begin
      d = {$urandom, $urandom};
      in_m[0] = d; in_r[0] = d; in_v[0] = 2'b11;
      step();
    end
    chk("A_status", 64'(e0_st), 64'd1);
    chk("A_cmp_count", 64'(e0_cc), 64'd100);
    chk("A_err_count", 64'(e0_ec), 64'd0);
    chk("A_err", 64'(e0_err), 64'd0);

    mid_reset();

    // Single ch1 mismatch at cycle 20
    for (int k = 0; k < 22; k++) begin
      d = {$urandom, $urandom};
      if (k == 20) begin
        d[63:32] = 32'd5;
        in_r[0] = {32'hFFFF_FFFB, d[31:0]};
      end else begin
        in_r[0] = d;
      end
      in_m[0] = d; in_v[0] = 2'b11;
      step();
      if (k == 20) begin
        chk("B_err", 64'(e0_err), 64'd2);
        chk("B_status", 64'(e0_st), 64'd2);
        chk("B_err_count", 64'(e0_ec), 64'd1);
        chk("B_first_chan", 64'(e0_fch), 64'd1);
        chk("B_first_meas", 64'(e0_fm), 64'd5);
        chk("B_first_ref", 64'(e0_fr), 64'hFFFF_FFFB);
        chk("B_first_cycle", 64'(e0_fcy), 64'd20);
      end
      if (k == 21) begin
        chk("B_err_next", 64'(e0_err), 64'd0);
        chk("B_status_sticky", 64'(e0_st), 64'd2);
      end
    end
    drive_idle();

    // Reference runs 3 cycles ahead of meas: delay 3 aligns, delay 2 does not
    for (int k = 0; k < 20; k++) begin
      s[k] = {$urandom, $urandom};
      s[k][7:0] = 8'(k);
      s[k][39:32] = 8'(k);
    end
    for (int k = 0; k < 20; k++) begin
      in_r[2] = s[k]; in_r[3] = s[k];
      in_m[2] = (k >= 3) ? s[k-3] : 64'd0;
      in_m[3] = in_m[2];
      in_v[2] = (k >= 3) ? 2'b11 : 2'b00;
      in_v[3] = in_v[2];
      step();
      if (k == 3) begin
        chk("C_d3_err_any", 64'(e2_any), 64'd0);
        chk("C_d2_err_any", 64'(e3_any), 64'd1);
        chk("C_d2_err", 64'(e3_err), 64'd3);
      end
    end
    chk("C_d3_err_count", 64'(e2_ec), 64'd0);
    chk("C_d3_cmp_count", 64'(e2_cc), 64'd34);
    chk("C_d3_status", 64'(e2_st), 64'd1);
    chk("C_d2_status", 64'(e3_st), 64'd2);
    drive_idle();

    // Clear, then simultaneous mismatch, then a later ch1 mismatch
    in_c[0] = 1'b1;
    step();
    in_c[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      d = {$urandom, $urandom};
      in_m[0] = d; in_r[0] = d; in_v[0] = 2'b11;
      step();
    end
    chk("D_status_check", 64'(e0_st), 64'd1);
    d = {$urandom, $urandom};
    fm0 = d[31:0];
    in_m[0] = d; in_r[0] = d ^ 64'h0000_0001_0000_0001;
    step();
    chk("D_err_both", 64'(e0_err), 64'd3);
    chk("D_err_count", 64'(e0_ec), 64'd2);
    chk("D_first_chan", 64'(e0_fch), 64'd0);
    chk("D_first_meas", 64'(e0_fm), 64'(fm0));
    chk("D_first_ref", 64'(e0_fr), 64'(fm0 ^ 32'd1));
    d = {$urandom, $urandom};
    in_m[0] = d; in_r[0] = d;
    step();
    d = {$urandom, $urandom};
    in_m[0] = d; in_r[0] = d ^ 64'h0000_0100_0000_0000;
    step();
    chk("D_late_err", 64'(e0_err), 64'd2);
    chk("D_late_first_chan", 64'(e0_fch), 64'd0);
    chk("D_late_first_meas", 64'(e0_fm), 64'(fm0));
    chk("D_late_err_count", 64'(e0_ec), 64'd3);
    drive_idle();

    // 4-bit counters saturate; clear wins over a same-cycle mismatch
    for (int k = 0; k < 20; k++) begin
      d = {$urandom, $urandom};
      in_m[1] = d; in_r[1] = d ^ 64'd1; in_v[1] = 2'b01;
      step();
    end
    chk("E_err_count_sat", 64'(e1_ec), 64'd15);
    chk("E_cmp_count_sat", 64'(e1_cc), 64'd15);
    chk("E_status", 64'(e1_st), 64'd2);
    in_c[1] = 1'b1;
    step();
    chk("E_clr_err", 64'(e1_err), 64'd0);
    chk("E_clr_err_count", 64'(e1_ec), 64'd0);
    chk("E_clr_cmp_count", 64'(e1_cc), 64'd0);
    chk("E_clr_status", 64'(e1_st), 64'd0);
    chk("E_clr_first_meas", 64'(e1_fm), 64'd0);
    drive_idle();

    // Unknown meas bits on a valid channel
    d = {$urandom, $urandom};
    in_m[0] = d; in_m[0][31:0] = 'x;
    in_r[0] = {d[63:32], 32'h5A5A_5A5A};
    in_v[0] = 2'b01;
    step();
    chk("F_x_err", 64'(e0_err), 64'd1);
    drive_idle();

    // Random mixed traffic with a mid-run reset
    for (int k = 0; k < 150; k++) begin
      for (int id = 0; id < 2; id++) begin
        d = {$urandom, $urandom};
        in_m[id] = d;
        in_r[id] = ($urandom_range(0, 3) == 0) ? (d ^ {$urandom, $urandom}) : d;
        in_v[id] = 2'($urandom_range(0, 3));
        in_c[id] = ($urandom_range(0, 19) == 0);
      end
      d = {$urandom, $urandom};
      gs.push_back(d);
      in_r[2] = d; in_r[3] = d;
      in_m[2] = (gs.size() > 3) ? gs[gs.size()-4] : 64'd0;
      if ($urandom_range(0, 7) == 0) in_m[2] = in_m[2] ^ 64'(1) << $urandom_range(0, 63);
      in_m[3] = in_m[2];
      in_v[2] = 2'($urandom_range(0, 3)); in_v[3] = in_v[2];
      in_c[2] = ($urandom_range(0, 29) == 0); in_c[3] = in_c[2];
      step();
      if (k == 75) begin
        mid_reset();
        gs.delete();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
